uart_tx_scheduler: RTL and testbench

//  Shares one uart_tx instance between N_REQ byte-stream requesters (debug dump, trace, status sources).

---
 rtl/uart_tx_scheduler_pkg.sv | 24 ++
 rtl/uart_tx_scheduler_rr_pick.sv | 37 +++
 rtl/uart_tx_scheduler.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   - FSM state encodings (S_IDLE .. S_GAP)
//   - default pacing parameters and the fixed grant index width
//   - small helper for sizing counters
package uart_tx_scheduler_pkg;

    localparam int GRANT_W          = 3;
    localparam int DEF_GAP_CYCLES   = 16;
    localparam int DEF_BUSY_TIMEOUT = 64;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TAKE    = 3'd1,
        S_STROBE  = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4,
        S_GAP     = 3'd5
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Round-robin picker (purely combinational).
//   req    : request vector, one bit per requester
//   ptr    : requester with highest priority this round
//   onehot : winner as a one-hot vector (zero when no request)
//   idx    : winner index
//   any    : at least one request present
module rr_pick
    import uart_tx_scheduler_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [N_REQ-1:0]   onehot,
    output logic [GRANT_W-1:0] idx,
    output logic               any
);

    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        any    = |req;
        // Walk from the farthest position back toward ptr so the last hit,
        // which is the one that sticks, is the first set bit at/after ptr.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (req[j]) begin
                onehot    = '0;
                onehot[j] = 1'b1;
                idx       = GRANT_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between N_REQ byte-stream requesters. Arbitration is
// round-robin per message: the owner keeps the UART until it hands over a
// byte tagged last. Each byte is sent as a one-cycle strobe, then the
// scheduler waits for busy to rise and fall and idles GAP_CYCLES before the
// next strobe. If busy never rises, the same byte is re-strobed.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/byte/last : per-requester byte stream (requester 0 in LSBs)
//   req_ready           : one-hot accept back to the owner
//   uart_valid/byte     : strobe and byte into uart_tx
//   uart_busy           : uart_tx busy
//   grant_id, active    : current owner and message-in-progress flag
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_byte,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 uart_valid,
    output logic [7:0]           uart_byte,
    input  logic                 uart_busy,
    output logic [GRANT_W-1:0]   grant_id,
    output logic                 active
);

    localparam int               CNT_W    = $clog2(max_int(GAP_CYCLES, BUSY_TIMEOUT)) + 1;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BT_LAST  = CNT_W'(BUSY_TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [GRANT_W-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]     grant_oh_q, grant_oh_d;
    logic [GRANT_W-1:0]   ptr_q, ptr_d;
    logic                 active_q, active_d;
    logic [7:0]           byte_q, byte_d;
    logic                 last_q, last_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [N_REQ-1:0]     pick_onehot;
    logic [GRANT_W-1:0]   pick_idx;
    logic                 pick_any;
    logic [7:0]           owner_byte;
    logic                 owner_last;
    logic                 accept;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req_valid),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Owner's byte/last, selected by the registered one-hot grant.
    always_comb begin
        owner_byte = '0;
        owner_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_oh_q[i]) begin
                owner_byte = req_byte[8*i +: 8];
                owner_last = req_last[i];
            end
        end
    end

    assign accept = (state_q == S_TAKE) && |(grant_oh_q & req_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            grant_oh_q <= '0;
            ptr_q      <= '0;
            active_q   <= 1'b0;
            byte_q     <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            ptr_q      <= ptr_d;
            active_q   <= active_d;
            byte_q     <= byte_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        ptr_d      = ptr_q;
        active_d   = active_q;
        byte_d     = byte_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_idx;
                    grant_oh_d = pick_onehot;
                    active_d   = 1'b1;
                    state_d    = S_TAKE;
                end
            end
            // Owner may stall here indefinitely; nobody else is considered.
            S_TAKE: begin
                if (accept) begin
                    byte_d  = owner_byte;
                    last_d  = owner_last;
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                cnt_d   = '0;
                state_d = S_WAIT_HI;
            end
            // No busy response within the timeout: resend the held byte.
            S_WAIT_HI: begin
                if (uart_busy)             state_d = S_WAIT_LO;
                else if (cnt_q >= BT_LAST) state_d = S_STROBE;
                else                       cnt_d   = cnt_q + 1'b1;
            end
            S_WAIT_LO: begin
                if (!uart_busy) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    if (last_q) begin
                        // Owner moves to lowest priority for the next message.
                        if (int'(grant_q) + 1 >= N_REQ) ptr_d = '0;
                        else                            ptr_d = grant_q + 1'b1;
                        active_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_TAKE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded straight from the state register so reset clears them
    // without waiting for a clock.
    always_comb begin
        req_ready  = '0;
        uart_valid = 1'b0;
        if (state_q == S_TAKE)   req_ready  = grant_oh_q & req_valid;
        if (state_q == S_STROBE) uart_valid = 1'b1;
    end

    assign uart_byte = byte_q;
    assign grant_id  = grant_q;
    assign active    = active_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

    localparam int N_REQ    = 2;
    localparam int GAP      = 4;
    localparam int BT       = 8;
    localparam int BUSY_LEN = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid = '0;
    logic [15:0]  req_byte  = '0;
    logic [1:0]   req_last  = '0;
    logic [1:0]   req_ready;
    logic         uart_valid;
    logic [7:0]   uart_byte;
    logic         uart_busy = 1'b0;
    logic [2:0]   grant_id;
    logic         active;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.N_REQ(N_REQ), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(BT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_byte   (req_byte),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .uart_valid (uart_valid),
        .uart_byte  (uart_byte),
        .uart_busy  (uart_busy),
        .grant_id   (grant_id),
        .active     (active)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [1:0] hold = '0;
    logic [1:0] acc  = '0;
    int         busy_mode = 1;
    int         busy_cnt  = 0;

    logic [7:0] s_byte[$];
    int         s_cyc[$];
    logic [2:0] s_gid[$];
    int         a_cyc[$];
    int         fall_cyc  = -1;
    logic       act_prev  = 1'b0;
    int         rdy_viol  = 0;
    logic       watch_rdy = 1'b0;
    logic       watch_pre = 1'b0;

    // One clock: sample at the falling edge, run the busy model, then the
    // requester drivers; accepts are predicted 1 time unit later.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (uart_valid) begin
            s_byte.push_back(uart_byte);
            s_cyc.push_back(cyc);
            s_gid.push_back(grant_id);
        end
        if (busy_mode == 1 && uart_valid) begin
            uart_busy = 1'b1;
            busy_cnt  = BUSY_LEN;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) uart_busy = 1'b0;
        end
        if (act_prev && !active) fall_cyc = cyc;
        act_prev = active;
        if (watch_rdy && req_ready != 2'b00) rdy_viol++;
        if (watch_pre && req_ready[0] && active && grant_id != 3'd0) rdy_viol++;
        if (acc[0] && q0.size() > 0) void'(q0.pop_front());
        if (acc[1] && q1.size() > 0) void'(q1.pop_front());
        acc = '0;
        if (q0.size() > 0 && !hold[0]) begin
            req_valid[0] = 1'b1; req_byte[7:0] = q0[0][7:0]; req_last[0] = q0[0][8];
        end else begin
            req_valid[0] = 1'b0; req_last[0] = 1'b0;
        end
        if (q1.size() > 0 && !hold[1]) begin
            req_valid[1] = 1'b1; req_byte[15:8] = q1[0][7:0]; req_last[1] = q1[0][8];
        end else begin
            req_valid[1] = 1'b0; req_last[1] = 1'b0;
        end
        #1;
        acc = req_valid & req_ready;
        if (acc != 2'b00) a_cyc.push_back(cyc);
    endtask

    task automatic clear_logs();
        s_byte.delete(); s_cyc.delete(); s_gid.delete(); a_cyc.delete();
        fall_cyc = -1;
        rdy_viol = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete(); q1.delete();
        hold = '0; acc = '0;
        busy_mode = 1; busy_cnt = 0; uart_busy = 1'b0;
        watch_rdy = 1'b0; watch_pre = 1'b0;
        step(); step();
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k = 0;
        while (s_byte.size() < n && k < budget) begin step(); k++; end
        checks++;
        if (s_byte.size() < n) begin
            errors++;
            $display("FAIL wait_strobes: got %0d strobes, expected %0d", s_byte.size(), n);
        end
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && !active) && k < budget) begin step(); k++; end
        checks++;
        if (active || q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL wait_done: active=%0b q0=%0d q1=%0d after %0d cycles", active, q0.size(), q1.size(), k);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #20;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
        checks++; if (uart_valid !== 1'b0) begin errors++; $display("FAIL reset_uart_valid: got %b expected 0", uart_valid); end
        checks++; if (uart_byte !== 8'h00) begin errors++; $display("FAIL reset_uart_byte: got %h expected 00", uart_byte); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active); end
        @(negedge clk); #1;
        rst_n = 1'b1;
        clear_logs();
    endtask

    // Strobe-to-strobe: STROBE, 1 WAIT_HI, WAIT_LO until busy (10 samples)
    // drops, 4 GAP, 1 TAKE -> 16 cycles. Active drops 15 cycles after the
    // final strobe.
    task automatic test_single_msg();
        logic [7:0] exp_b [0:2] = '{8'h41, 8'h42, 8'h0A};
        q0.push_back({1'b0, 8'h41}); q0.push_back({1'b0, 8'h42}); q0.push_back({1'b1, 8'h0A});
        wait_done(200);
        checks++; if (s_byte.size() != 3) begin errors++; $display("FAIL t1_count: got %0d expected 3", s_byte.size()); end
        if (s_byte.size() == 3 && a_cyc.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (s_byte[k] !== exp_b[k] || s_gid[k] !== 3'd0) begin
                    errors++; $display("FAIL t1_byte%0d: got %h/gid%0d expected %h/gid0", k, s_byte[k], s_gid[k], exp_b[k]);
                end
            end
            checks++; if (s_cyc[0] != a_cyc[0] + 1) begin errors++; $display("FAIL t1_latency: got %0d expected 1", s_cyc[0] - a_cyc[0]); end
            checks++; if (s_cyc[1] - s_cyc[0] != 16) begin errors++; $display("FAIL t1_interval: got %0d expected 16", s_cyc[1] - s_cyc[0]); end
            checks++; if (fall_cyc != s_cyc[2] + 15) begin errors++; $display("FAIL t1_active_fall: got %0d expected %0d", fall_cyc, s_cyc[2] + 15); end
        end
    endtask

    task automatic test_two_requesters();
        logic [7:0] exp_b [0:3] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1};
        logic [2:0] exp_g [0:3] = '{3'd0, 3'd0, 3'd1, 3'd1};
        do_reset();
        q0.push_back({1'b0, 8'hA0}); q0.push_back({1'b1, 8'hA1});
        q1.push_back({1'b0, 8'hB0}); q1.push_back({1'b1, 8'hB1});
        wait_done(300);
        checks++; if (s_byte.size() != 4) begin errors++; $display("FAIL t2_count: got %0d expected 4", s_byte.size()); end
        if (s_byte.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (s_byte[k] !== exp_b[k] || s_gid[k] !== exp_g[k]) begin
                    errors++; $display("FAIL t2_order%0d: got %h/gid%0d expected %h/gid%0d", k, s_byte[k], s_gid[k], exp_b[k], exp_g[k]);
                end
            end
        end
        // Pointer wrapped back to 0: requester 0 must win a tie again.
        clear_logs();
        q0.push_back({1'b1, 8'hC0});
        q1.push_back({1'b1, 8'hD0});
        wait_done(200);
        checks++;
        if (s_byte.size() != 2 || s_byte[0] !== 8'hC0 || s_byte[1] !== 8'hD0) begin
            errors++; $display("FAIL t2_ptr_wrap: got %0d strobes first=%h expected C0 then D0", s_byte.size(), (s_byte.size() > 0) ? s_byte[0] : 8'hxx);
        end
    endtask

    task automatic test_no_preempt();
        logic [7:0] exp_b [0:3] = '{8'h31, 8'h32, 8'h33, 8'hC5};
        do_reset();
        q1.push_back({1'b0, 8'h31}); q1.push_back({1'b0, 8'h32}); q1.push_back({1'b1, 8'h33});
        wait_strobes(1, 50);
        q0.push_back({1'b1, 8'hC5});
        watch_pre = 1'b1;
        wait_done(300);
        checks++; if (rdy_viol != 0) begin errors++; $display("FAIL t3_preempt: got %0d ready cycles to req0 expected 0", rdy_viol); end
        checks++; if (s_byte.size() != 4) begin errors++; $display("FAIL t3_count: got %0d expected 4", s_byte.size()); end
        if (s_byte.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (s_byte[k] !== exp_b[k]) begin errors++; $display("FAIL t3_order%0d: got %h expected %h", k, s_byte[k], exp_b[k]); end
            end
            checks++; if (s_gid[3] !== 3'd0) begin errors++; $display("FAIL t3_gid: got %0d expected 0", s_gid[3]); end
            // GAP ends at s+14, IDLE s+15, TAKE s+16, STROBE s+17.
            checks++; if (s_cyc[3] != s_cyc[2] + 17) begin errors++; $display("FAIL t3_handover: got %0d expected 17", s_cyc[3] - s_cyc[2]); end
        end
    endtask

    task automatic test_busy_timeout();
        do_reset();
        busy_mode = 0;
        q0.push_back({1'b1, 8'h5A});
        wait_strobes(1, 50);
        watch_rdy = 1'b1;
        wait_strobes(3, 100);
        if (s_byte.size() >= 3) begin
            checks++; if (s_cyc[1] - s_cyc[0] != BT + 1) begin errors++; $display("FAIL t4_period1: got %0d expected %0d", s_cyc[1] - s_cyc[0], BT + 1); end
            checks++; if (s_cyc[2] - s_cyc[1] != BT + 1) begin errors++; $display("FAIL t4_period2: got %0d expected %0d", s_cyc[2] - s_cyc[1], BT + 1); end
            checks++;
            if (s_byte[1] !== 8'h5A || s_byte[2] !== 8'h5A) begin
                errors++; $display("FAIL t4_same_byte: got %h,%h expected 5A,5A", s_byte[1], s_byte[2]);
            end
        end
        busy_mode = 1;
        wait_done(200);
        checks++; if (a_cyc.size() != 1) begin errors++; $display("FAIL t4_accepts: got %0d expected 1", a_cyc.size()); end
        checks++; if (s_byte.size() != 4) begin errors++; $display("FAIL t4_strobes: got %0d expected 4", s_byte.size()); end
        checks++; if (rdy_viol != 0) begin errors++; $display("FAIL t4_ready_low: got %0d ready cycles expected 0", rdy_viol); end
    endtask

    task automatic test_owner_stall();
        int rel;
        do_reset();
        q1.push_back({1'b0, 8'h11}); q1.push_back({1'b0, 8'h22}); q1.push_back({1'b1, 8'h33});
        wait_strobes(1, 50);
        hold[1] = 1'b1;
        repeat (36) step();
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL t5_active: got %b expected 1", active); end
        checks++; if (grant_id !== 3'd1) begin errors++; $display("FAIL t5_grant: got %0d expected 1", grant_id); end
        checks++; if (s_byte.size() != 1) begin errors++; $display("FAIL t5_no_strobe: got %0d strobes expected 1", s_byte.size()); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL t5_ready: got %b expected 00", req_ready); end
        rel = cyc;
        hold[1] = 1'b0;
        wait_done(200);
        checks++; if (s_byte.size() != 3) begin errors++; $display("FAIL t5_count: got %0d expected 3", s_byte.size()); end
        if (s_byte.size() == 3) begin
            checks++;
            if (s_byte[1] !== 8'h22 || s_byte[2] !== 8'h33) begin
                errors++; $display("FAIL t5_bytes: got %h,%h expected 22,33", s_byte[1], s_byte[2]);
            end
            checks++; if (s_cyc[1] != rel + 2) begin errors++; $display("FAIL t5_resume: got %0d expected %0d", s_cyc[1], rel + 2); end
        end
    endtask

    task automatic test_reset_mid_msg();
        do_reset();
        q1.push_back({1'b0, 8'h61}); q1.push_back({1'b0, 8'h62}); q1.push_back({1'b1, 8'h63});
        wait_strobes(2, 100);
        repeat (4) step();                 // inside WAIT_LO of byte 2
        checks++;
        if (active !== 1'b1 || uart_byte !== 8'h62 || grant_id !== 3'd1) begin
            errors++; $display("FAIL t6_pre: got active=%b byte=%h gid=%0d expected 1/62/1", active, uart_byte, grant_id);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (uart_valid !== 1'b0) begin errors++; $display("FAIL t6_uart_valid: got %b expected 0", uart_valid); end
        checks++; if (uart_byte !== 8'h00) begin errors++; $display("FAIL t6_uart_byte: got %h expected 00", uart_byte); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL t6_active: got %b expected 0", active); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL t6_grant: got %0d expected 0", grant_id); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL t6_ready: got %b expected 00", req_ready); end
        do_reset();
        q0.push_back({1'b0, 8'h71}); q0.push_back({1'b1, 8'h72});
        wait_done(200);
        checks++; if (s_byte.size() != 2) begin errors++; $display("FAIL t6_count: got %0d expected 2", s_byte.size()); end
        if (s_byte.size() == 2 && a_cyc.size() == 2) begin
            checks++;
            if (s_byte[0] !== 8'h71 || s_byte[1] !== 8'h72 || s_gid[0] !== 3'd0) begin
                errors++; $display("FAIL t6_restart: got %h,%h gid%0d expected 71,72 gid0", s_byte[0], s_byte[1], s_gid[0]);
            end
            checks++; if (s_cyc[0] != a_cyc[0] + 1) begin errors++; $display("FAIL t6_latency: got %0d expected 1", s_cyc[0] - a_cyc[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_msg();
        test_two_requesters();
        test_no_preempt();
        test_busy_timeout();
        test_owner_stall();
        test_reset_mid_msg();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
